// File: rtl/stereo_predelay.sv
// Stereo predelay line: each accepted {left,right} frame goes into a circular RAM,
// and the frame written predelay_value frames earlier is emitted. Zeros are emitted until enough history exists.
module stereo_predelay #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_left_data,
   input  logic              in_left_valid,
   output logic              in_left_ready,
   input  logic [DATA_W-1:0] in_right_data,
   input  logic              in_right_valid,
   output logic              in_right_ready,
   input  logic [ADDR_W-1:0] predelay_value,
   output logic [DATA_W-1:0] out_left_data,
   output logic              out_left_valid,
   input  logic              out_left_ready,
   output logic [DATA_W-1:0] out_right_data,
   output logic              out_right_valid,
   input  logic              out_right_ready
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;
   localparam logic [ADDR_W-1:0] FILL_MAX = '1;

   logic [1:0]          state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic                zero_q, zero_d;
   logic                bypass_q, bypass_d;
   logic [2*DATA_W-1:0] byp_data_q, byp_data_d;
   logic [DATA_W-1:0]   out_l_q, out_l_d;
   logic [DATA_W-1:0]   out_r_q, out_r_d;
   logic                lv_q, lv_d;
   logic                rv_q, rv_d;

   logic [2*DATA_W-1:0] ram_q [0:(1<<ADDR_W)-1];
   logic [2*DATA_W-1:0] rd_data_q;
   logic [ADDR_W-1:0]   rd_addr;
   logic                accept;

   // A frame moves only when both channels are valid together.
   assign accept  = (state_q == IDLE) & in_left_valid & in_right_valid;
   assign rd_addr = wr_ptr_q - predelay_value;

   assign in_left_ready   = (state_q == IDLE);
   assign in_right_ready  = (state_q == IDLE);
   assign out_left_data   = out_l_q;
   assign out_right_data  = out_r_q;
   assign out_left_valid  = lv_q;
   assign out_right_valid = rv_q;

   // Storage is not reset; fill_cnt keeps stale words from ever reaching the output.
   always_ff @(posedge clk) begin
      if (accept) begin
         ram_q[wr_ptr_q] <= {in_left_data, in_right_data};
         rd_data_q       <= ram_q[rd_addr];
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      fill_cnt_d = fill_cnt_q;
      zero_d     = zero_q;
      bypass_d   = bypass_q;
      byp_data_d = byp_data_q;
      out_l_d    = out_l_q;
      out_r_d    = out_r_q;
      lv_d       = lv_q;
      rv_d       = rv_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               zero_d     = (predelay_value > fill_cnt_q);
               bypass_d   = (predelay_value == '0);
               byp_data_d = {in_left_data, in_right_data};
               wr_ptr_d   = wr_ptr_q + 1'b1;
               if (fill_cnt_q != FILL_MAX) fill_cnt_d = fill_cnt_q + 1'b1;
               state_d    = READ;
            end
         end
         READ: begin
            if (zero_q) begin
               out_l_d = '0;
               out_r_d = '0;
            end else if (bypass_q) begin
               out_l_d = byp_data_q[2*DATA_W-1:DATA_W];
               out_r_d = byp_data_q[DATA_W-1:0];
            end else begin
               out_l_d = rd_data_q[2*DATA_W-1:DATA_W];
               out_r_d = rd_data_q[DATA_W-1:0];
            end
            lv_d    = 1'b1;
            rv_d    = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            lv_d = lv_q & ~out_left_ready;
            rv_d = rv_q & ~out_right_ready;
            if (!lv_d && !rv_d) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         fill_cnt_q <= '0;
         zero_q     <= 1'b0;
         bypass_q   <= 1'b0;
         byp_data_q <= '0;
         out_l_q    <= '0;
         out_r_q    <= '0;
         lv_q       <= 1'b0;
         rv_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_cnt_q <= fill_cnt_d;
         zero_q     <= zero_d;
         bypass_q   <= bypass_d;
         byp_data_q <= byp_data_d;
         out_l_q    <= out_l_d;
         out_r_q    <= out_r_d;
         lv_q       <= lv_d;
         rv_q       <= rv_d;
      end
   end

endmodule
